mesh_vc_link_buffer: RTL and testbench

Parametrised virtual-channel link buffer inserted on any router-to-router or edge link of the mesh. It accepts packets on a send/ready handshake, queues them per virtual channel (VC) in independent FIFOs, and forwards them downstream under a round-robin VC arbiter gated by per-VC downstream ready. It generalises the fixed two-channel (even/odd polarity) links to NUM_VC channels with configurable depth and width, and adds drop accounting.

---
 rtl/mesh_vc_link_buffer.sv | 125 ++++++++++++
 tb/tb_mesh_vc_link_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_vc_link_buffer.sv
// Virtual-channel link buffer: per-VC FIFOs on the upstream side, a round-robin
// arbiter gated by per-VC downstream ready, and a registered output stage.
// Packets whose VC FIFO is full are dropped and counted (saturating).
module mesh_vc_link_buffer #(
    parameter int unsigned PACKET_WIDTH = 64,
    parameter int unsigned NUM_VC       = 2,
    parameter int unsigned DEPTH        = 4,
    localparam int unsigned VC_BITS     = $clog2(NUM_VC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_si,
    input  logic [PACKET_WIDTH-1:0] in_di,
    output logic [NUM_VC-1:0]       in_ri,
    output logic                    out_so,
    output logic [PACKET_WIDTH-1:0] out_do,
    output logic [VC_BITS-1:0]      out_vc,
    input  logic [NUM_VC-1:0]       out_ro,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    logic [VC_BITS-1:0]                  in_vc;
    logic                                push;
    logic                                drop;
    logic [NUM_VC-1:0]                   not_empty;
    logic [NUM_VC-1:0]                   eligible;
    logic [NUM_VC-1:0][PACKET_WIDTH-1:0] head;
    logic                                grant_valid;
    logic [VC_BITS-1:0]                  grant_vc;
    logic [VC_BITS-1:0]                  rr_q;

    assign in_vc    = in_di[PACKET_WIDTH-1 -: VC_BITS];
    // Readiness comes from registered counts only, so push never depends on the pop path.
    assign push     = in_si && in_ri[in_vc];
    assign drop     = in_si && !in_ri[in_vc];
    assign eligible = not_empty & out_ro;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_BITS-1:0]     wr_ptr_q;
        logic [PTR_BITS-1:0]     rd_ptr_q;
        logic [CNT_BITS-1:0]     cnt_q;
        logic                    push_v;
        logic                    pop_v;

        assign push_v       = push && (in_vc == VC_BITS'(v));
        assign pop_v        = grant_valid && (grant_vc == VC_BITS'(v));
        assign in_ri[v]     = (cnt_q != CNT_BITS'(DEPTH));
        assign not_empty[v] = (cnt_q != '0);
        assign head[v]      = mem_q[rd_ptr_q];

        // Storage needs no reset: entries are only read once counted in.
        always_ff @(posedge clk) begin
            if (push_v) begin
                mem_q[wr_ptr_q] <= in_di;
            end
        end

        // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push_v) begin
                    wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
                end
                if (pop_v) begin
                    rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
                end
                if (push_v && !pop_v) begin
                    cnt_q <= cnt_q + CNT_BITS'(1);
                end else if (pop_v && !push_v) begin
                    cnt_q <= cnt_q - CNT_BITS'(1);
                end
            end
        end
    end

    // Round-robin search from rr, wrapping modulo NUM_VC (power of two, so add wraps).
    always_comb begin
        logic [VC_BITS-1:0] cand;
        grant_valid = 1'b0;
        grant_vc    = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            cand = rr_q + VC_BITS'(i);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_vc    = cand;
            end
        end
    end

    // Registered output stage and arbiter pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_so <= 1'b0;
            out_do <= '0;
            out_vc <= '0;
            rr_q   <= '0;
        end else begin
            out_so <= grant_valid;
            if (grant_valid) begin
                out_do <= head[grant_vc];
                out_vc <= grant_vc;
                rr_q   <= grant_vc + VC_BITS'(1);
            end
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mesh_vc_link_buffer.sv
// Scoreboard bench for mesh_vc_link_buffer (NUM_VC=2, DEPTH=4, 64-bit packets).
module tb_mesh_vc_link_buffer;

    logic        clk;
    logic        reset;
    logic        in_si;
    logic [63:0] in_di;
    logic [1:0]  in_ri;
    logic        out_so;
    logic [63:0] out_do;
    logic [0:0]  out_vc;
    logic [1:0]  out_ro;
    logic [7:0]  drop_cnt;

    typedef struct {
        int          cyc;
        logic        vc;
        logic [63:0] d;
    } obs_t;

    obs_t obs_q[$];
    obs_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    mesh_vc_link_buffer #(
        .PACKET_WIDTH(64),
        .NUM_VC      (2),
        .DEPTH       (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_si   (in_si),
        .in_di   (in_di),
        .in_ri   (in_ri),
        .out_so  (out_so),
        .out_do  (out_do),
        .out_vc  (out_vc),
        .out_ro  (out_ro),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every forwarded packet shortly after the edge.
    always @(posedge clk) begin
        obs_t o;
        #1;
        if (out_so === 1'b1) begin
            o.cyc = cyc;
            o.vc  = out_vc[0];
            o.d   = out_do;
            obs_q.push_back(o);
        end
    end

    function automatic logic [63:0] mk(input logic vc, input logic [15:0] tag);
        return {vc, 47'd0, tag};
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic send(input logic [63:0] d);
        in_si = 1'b1;
        in_di = d;
        @(negedge clk);
        in_si = 1'b0;
    endtask

    task automatic send_exp(input logic [63:0] d);
        obs_t e;
        e.cyc = cyc + 2;
        e.vc  = d[63];
        e.d   = d;
        exp_q.push_back(e);
        send(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_si  = 1'b0;
        in_di  = '0;
        reset  = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ro = 2'b11;
        #1;
        n_checks++;
        if (in_ri !== 2'b11) $display("FAIL reset_in_ri: got %b want 11", in_ri);
        else n_pass++;
        n_checks++;
        if (out_so !== 1'b0) $display("FAIL reset_out_so: got %b want 0", out_so);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        else n_pass++;
        n_checks++;
        if (out_do !== 64'd0 || out_vc !== 1'b0)
            $display("FAIL reset_out_data: got do=%h vc=%b want 0/0", out_do, out_vc);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single();
        do_reset();
        out_ro = 2'b11;
        send_exp(64'h8000_0000_0000_00AA);
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1) $display("FAIL single_count: got %0d want 1", obs_q.size());
        else n_pass++;
        if (obs_q.size() >= 1) begin
            n_checks++;
            if (obs_q[0].vc !== 1'b1 || obs_q[0].d !== 64'h8000_0000_0000_00AA ||
                obs_q[0].cyc != exp_q[0].cyc)
                $display("FAIL single_pkt: got vc=%b d=%h cyc=%0d want vc=1 d=%h cyc=%0d",
                         obs_q[0].vc, obs_q[0].d, obs_q[0].cyc, exp_q[0].d, exp_q[0].cyc);
            else n_pass++;
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        out_ro = 2'b00;
        for (int i = 0; i < 4; i++) send_exp(mk(1'b0, 16'hA0 + 16'(i)));
        n_checks++;
        if (in_ri !== 2'b10) $display("FAIL full_in_ri: got %b want 10", in_ri);
        else n_pass++;
        send(mk(1'b0, 16'hDD0));
        send(mk(1'b0, 16'hDD1));
        n_checks++;
        if (drop_cnt !== 8'd2) $display("FAIL full_drop_cnt: got %0d want 2", drop_cnt);
        else n_pass++;
        n_checks++;
        if (in_ri !== 2'b10) $display("FAIL full_in_ri_after_drop: got %b want 10", in_ri);
        else n_pass++;
        out_ro = 2'b01;
        repeat (8) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL full_count: got %0d want 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].vc !== exp_q[i].vc || obs_q[i].d !== exp_q[i].d)
                $display("FAIL full_data[%0d]: got %h want %h", i, obs_q[i].d, exp_q[i].d);
            else n_pass++;
        end
    endtask

    task automatic fill_ab();
        out_ro = 2'b00;
        for (int i = 0; i < 4; i++) send(mk(1'b0, 16'hA0 + 16'(i)));
        for (int i = 0; i < 4; i++) send(mk(1'b1, 16'hB0 + 16'(i)));
    endtask

    task automatic test_round_robin();
        obs_t e;
        do_reset();
        fill_ab();
        for (int i = 0; i < 4; i++) begin
            e.cyc = 0; e.vc = 1'b0; e.d = mk(1'b0, 16'hA0 + 16'(i)); exp_q.push_back(e);
            e.cyc = 0; e.vc = 1'b1; e.d = mk(1'b1, 16'hB0 + 16'(i)); exp_q.push_back(e);
        end
        out_ro = 2'b11;
        repeat (12) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 8) $display("FAIL rr_count: got %0d want 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].vc !== exp_q[i].vc || obs_q[i].d !== exp_q[i].d ||
                obs_q[i].cyc != obs_q[0].cyc + i)
                $display("FAIL rr_order[%0d]: got vc=%b d=%h cyc=%0d want vc=%b d=%h cyc=%0d",
                         i, obs_q[i].vc, obs_q[i].d, obs_q[i].cyc, exp_q[i].vc, exp_q[i].d,
                         obs_q[0].cyc + i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        obs_t e;
        do_reset();
        fill_ab();
        for (int i = 0; i < 4; i++) begin
            e.cyc = 0; e.vc = 1'b1; e.d = mk(1'b1, 16'hB0 + 16'(i)); exp_q.push_back(e);
        end
        out_ro = 2'b10;
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL bp_b_count: got %0d want 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].vc !== exp_q[i].vc || obs_q[i].d !== exp_q[i].d)
                $display("FAIL bp_b[%0d]: got %h want %h", i, obs_q[i].d, exp_q[i].d);
            else n_pass++;
        end
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            e.cyc = 0; e.vc = 1'b0; e.d = mk(1'b0, 16'hA0 + 16'(i)); exp_q.push_back(e);
        end
        out_ro = 2'b11;
        repeat (8) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL bp_a_count: got %0d want 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].vc !== exp_q[i].vc || obs_q[i].d !== exp_q[i].d)
                $display("FAIL bp_a[%0d]: got %h want %h", i, obs_q[i].d, exp_q[i].d);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int not_ready = 0;
        do_reset();
        out_ro = 2'b01;
        for (int i = 0; i < 20; i++) begin
            if (in_ri[0] !== 1'b1) not_ready++;
            send_exp(mk(1'b0, 16'h100 + 16'(i)));
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (not_ready != 0) $display("FAIL stream_in_ri: got %0d not-ready cycles want 0", not_ready);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 8'd0) $display("FAIL stream_drops: got %0d want 0", drop_cnt);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 20) $display("FAIL stream_count: got %0d want 20", obs_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].cyc != exp_q[i].cyc)
                $display("FAIL stream[%0d]: got d=%h cyc=%0d want d=%h cyc=%0d",
                         i, obs_q[i].d, obs_q[i].cyc, exp_q[i].d, exp_q[i].cyc);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ro = 2'b00;
        for (int i = 0; i < 3; i++) send(mk(1'b0, 16'hC0 + 16'(i)));
        out_ro = 2'b01;
        @(negedge clk);
        n_checks++;
        if (out_so !== 1'b1) $display("FAIL midrst_pre_out_so: got %b want 1", out_so);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_so !== 1'b0) $display("FAIL midrst_out_so: got %b want 0", out_so);
        else n_pass++;
        n_checks++;
        if (in_ri !== 2'b11) $display("FAIL midrst_in_ri: got %b want 11", in_ri);
        else n_pass++;
        @(negedge clk);
        reset  = 1'b1;
        out_ro = 2'b11;
        obs_q.delete();
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL midrst_stale: got %0d packets want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_drop_saturation();
        do_reset();
        out_ro = 2'b00;
        for (int i = 0; i < 4; i++) send(mk(1'b0, 16'(i)));
        for (int i = 0; i < 254; i++) send(mk(1'b0, 16'hE00));
        n_checks++;
        if (drop_cnt !== 8'd254) $display("FAIL sat_254: got %0d want 254", drop_cnt);
        else n_pass++;
        for (int i = 0; i < 46; i++) send(mk(1'b0, 16'hE00));
        n_checks++;
        if (drop_cnt !== 8'd255) $display("FAIL sat_300: got %0d want 255", drop_cnt);
        else n_pass++;
        n_checks++;
        if (in_ri !== 2'b10) $display("FAIL sat_in_ri: got %b want 10", in_ri);
        else n_pass++;
    endtask

    initial begin
        reset  = 1'b1;
        in_si  = 1'b0;
        in_di  = '0;
        out_ro = 2'b00;
        test_reset();
        test_single();
        test_full_drop();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_drop_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
